// File: rtl/perip_pkg.sv
// Shared peripheral-bridge definitions: MMIO offsets, counter command words, access sizes.
// Also holds the byte-lane merge used by the writable MMIO registers.
package perip_pkg;

  localparam logic [11:0] OFF_SW  = 12'h000;
  localparam logic [11:0] OFF_KEY = 12'h010;
  localparam logic [11:0] OFF_SEG = 12'h020;
  localparam logic [11:0] OFF_LED = 12'h040;
  localparam logic [11:0] OFF_CNT = 12'h050;

  localparam logic [31:0] CNT_START = 32'h8000_0000;
  localparam logic [31:0] CNT_STOP  = 32'hFFFF_FFFF;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef enum logic [1:0] {
    CNT_IDLE,
    CNT_RUN,
    CNT_HOLD
  } cnt_state_t;

  // Store data arrives already lane-aligned, so only the enabled lanes are replaced.
  function automatic logic [31:0] lane_merge(
    input logic [31:0] cur,
    input logic [31:0] wdata,
    input logic [1:0]  byte_off,
    input logic [1:0]  mask
  );
    logic [3:0]  be;
    logic [31:0] res;
    case (mask)
      MASK_BYTE: be = 4'b0001 << byte_off;
      MASK_HALF: be = byte_off[1] ? 4'b1100 : 4'b0011;
      MASK_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/perip_bridge_key_debounce.sv
// One push-button: 2-flop synchronizer plus hold-time debounce; accepted level lags the pin
// by 2 sync cycles plus DEBOUNCE_CYCLES stable cycles. No flow control.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic        meta;
  logic        sync;
  logic [19:0] cnt;

  // Counter only advances while the synced pin disagrees with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= 20'd0;
      level <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= 20'd0;
      end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
        level <= sync;
        cnt   <= 20'd0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/perip_bridge.sv
// Data-bus decoder between the core and DRAM/MMIO peripherals (switches, keys, LED, 7-seg, ms counter).
// Reads are combinational (zero latency), writes land on the strobe edge; no backpressure.
module perip_bridge
  import perip_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE       = 32'h8010_0000,
  parameter int          DRAM_AW         = 16,
  parameter logic [31:0] MMIO_BASE       = 32'h8020_0000,
  parameter int          CLK_PER_MS      = 50000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        perip_addr,
  input  logic               perip_wen,
  input  logic [1:0]         perip_mask,
  input  logic [31:0]        perip_wdata,
  output logic [31:0]        perip_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [1:0]         dram_mask,
  output logic [1:0]         dram_byte,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [15:0]        sw,
  input  logic [4:0]         key,
  output logic [15:0]        led,
  output logic [31:0]        seg_data
);

  localparam int          PW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [32:0] DRAM_LIMIT = {1'b0, DRAM_BASE} + (33'd1 << (DRAM_AW + 2));

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [4:0]  key_level;

  logic        dram_hit;
  logic        mmio_hit;
  logic [9:0]  word_off;
  logic        seg_sel;
  logic        led_sel;
  logic        cnt_sel;
  logic [31:0] seg_next;
  logic [15:0] led_next;
  logic        cnt_start;
  logic        cnt_stop;

  cnt_state_t  cnt_state;
  logic [31:0] cnt_ms;
  logic [PW-1:0] prescaler;

  assign dram_hit = (perip_addr >= DRAM_BASE) && ({1'b0, perip_addr} < DRAM_LIMIT);
  assign mmio_hit = (perip_addr[31:12] == MMIO_BASE[31:12]);
  assign word_off = perip_addr[11:2];

  assign dram_addr  = perip_addr[DRAM_AW+1:2];
  assign dram_wen   = perip_wen & dram_hit;
  assign dram_mask  = perip_mask;
  assign dram_byte  = perip_addr[1:0];
  assign dram_wdata = perip_wdata;

  assign seg_sel = mmio_hit && (word_off == OFF_SEG[11:2]);
  assign led_sel = mmio_hit && (word_off == OFF_LED[11:2]);
  assign cnt_sel = mmio_hit && (word_off == OFF_CNT[11:2]);

  assign seg_next = lane_merge(seg_data, perip_wdata, perip_addr[1:0], perip_mask);
  assign led_next = 16'(lane_merge({16'h0, led}, perip_wdata, perip_addr[1:0], perip_mask));

  // Counter commands are whole-word only; anything narrower is silently ignored.
  assign cnt_start = perip_wen && cnt_sel && (perip_mask == MASK_WORD) && (perip_wdata == CNT_START);
  assign cnt_stop  = perip_wen && cnt_sel && (perip_mask == MASK_WORD) && (perip_wdata == CNT_STOP);

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      sw_meta <= 16'h0;
      sw_sync <= 16'h0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk   (cpu_clk),
      .rst   (cpu_rst),
      .raw   (key[i]),
      .level (key_level[i])
    );
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      seg_data <= 32'h0;
      led      <= 16'h0;
    end else if (perip_wen) begin
      if (seg_sel) seg_data <= seg_next;
      if (led_sel) led      <= led_next;
    end
  end

  // Start has priority over both stop and a same-cycle prescaler wrap.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt_state <= CNT_IDLE;
      cnt_ms    <= 32'h0;
      prescaler <= '0;
    end else if (cnt_start) begin
      cnt_state <= CNT_RUN;
      cnt_ms    <= 32'h0;
      prescaler <= '0;
    end else if (cnt_stop && (cnt_state == CNT_RUN)) begin
      cnt_state <= CNT_HOLD;
    end else if (cnt_state == CNT_RUN) begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        cnt_ms    <= cnt_ms + 32'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  always_comb begin
    perip_rdata = 32'h0;
    if (dram_hit) begin
      perip_rdata = dram_rdata;
    end else if (mmio_hit) begin
      case (word_off)
        OFF_SW[11:2]:  perip_rdata = {16'h0, sw_sync};
        OFF_KEY[11:2]: perip_rdata = {27'h0, key_level};
        OFF_SEG[11:2]: perip_rdata = seg_data;
        OFF_LED[11:2]: perip_rdata = {16'h0, led};
        OFF_CNT[11:2]: perip_rdata = cnt_ms;
        default:       perip_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_perip_bridge.sv
// Self-checking bench for perip_bridge with a fast counter and short debounce.
module tb_perip_bridge;

  localparam logic [31:0] DRAM_BASE = 32'h8010_0000;
  localparam logic [31:0] MMIO_BASE = 32'h8020_0000;
  localparam logic [31:0] A_SW  = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_KEY = MMIO_BASE + 32'h10;
  localparam logic [31:0] A_SEG = MMIO_BASE + 32'h20;
  localparam logic [31:0] A_LED = MMIO_BASE + 32'h40;
  localparam logic [31:0] A_CNT = MMIO_BASE + 32'h50;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] perip_addr;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [31:0] perip_wdata;
  logic [31:0] perip_rdata;
  logic [15:0] dram_addr;
  logic        dram_wen;
  logic [1:0]  dram_mask;
  logic [1:0]  dram_byte;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [15:0] sw;
  logic [4:0]  key;
  logic [15:0] led;
  logic [31:0] seg_data;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  perip_bridge #(
    .DRAM_BASE      (DRAM_BASE),
    .DRAM_AW        (16),
    .MMIO_BASE      (MMIO_BASE),
    .CLK_PER_MS     (4),
    .DEBOUNCE_CYCLES(20'd8)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .perip_addr  (perip_addr),
    .perip_wen   (perip_wen),
    .perip_mask  (perip_mask),
    .perip_wdata (perip_wdata),
    .perip_rdata (perip_rdata),
    .dram_addr   (dram_addr),
    .dram_wen    (dram_wen),
    .dram_mask   (dram_mask),
    .dram_byte   (dram_byte),
    .dram_wdata  (dram_wdata),
    .dram_rdata  (dram_rdata),
    .sw          (sw),
    .key         (key),
    .led         (led),
    .seg_data    (seg_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // Compare the current combinational read data against the oldest queued expectation.
  task automatic sb_cmp(input string tag);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got %08h", tag, perip_rdata);
    end else begin
      chk(tag, perip_rdata, exp_q.pop_front());
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr);
    perip_addr = addr;
    perip_wen  = 1'b0;
    perip_mask = 2'b10;
    sb_cmp(tag);
  endtask

  // Called at a negedge; the store is sampled on the following posedge.
  task automatic wr(input logic [31:0] addr, input logic [1:0] mask, input logic [31:0] data);
    perip_addr  = addr;
    perip_mask  = mask;
    perip_wdata = data;
    perip_wen   = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    perip_wen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  initial begin
    cpu_rst     = 1'b1;
    perip_addr  = 32'h0;
    perip_wen   = 1'b0;
    perip_mask  = 2'b10;
    perip_wdata = 32'h0;
    dram_rdata  = 32'h0;
    sw          = 16'h0;
    key         = 5'h0;
    idle(2);
    cpu_rst = 1'b0;

    chk("rst_led", 32'(led), 32'h0);
    chk("rst_seg", seg_data, 32'h0);
    push_exp(32'h0); rd_chk("rst_cnt", A_CNT);
    push_exp(32'h0); rd_chk("rst_key", A_KEY);
    push_exp(32'h0); rd_chk("rst_sw", A_SW);

    sw = 16'hA5C3;
    idle(1);
    push_exp(32'h0); rd_chk("sw_1cyc", A_SW);
    idle(1);
    push_exp(32'h0000_A5C3); rd_chk("sw_2cyc", A_SW);

    wr(A_SEG, 2'b10, 32'h1234_5678);
    chk("seg_word", seg_data, 32'h1234_5678);
    perip_addr  = A_SEG + 32'd2;
    perip_mask  = 2'b00;
    perip_wdata = 32'h00AB_0000;
    perip_wen   = 1'b1;
    push_exp(32'h1234_5678); sb_cmp("seg_rd_before_wr");
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    perip_wen = 1'b0;
    chk("seg_byte", seg_data, 32'h12AB_5678);
    push_exp(32'h12AB_5678); rd_chk("seg_rd", A_SEG);

    wr(A_LED, 2'b01, 32'h0000_BEEF);
    chk("led_half", 32'(led), 32'h0000_BEEF);
    wr(A_LED + 32'd3, 2'b00, 32'h7700_0000);
    chk("led_hi_lane", 32'(led), 32'h0000_BEEF);
    push_exp(32'h0000_BEEF); rd_chk("led_rd", A_LED);

    wr(MMIO_BASE + 32'h30, 2'b10, 32'hFFFF_FFFF);
    push_exp(32'h0); rd_chk("mmio_hole_rd", MMIO_BASE + 32'h30);
    chk("hole_led", 32'(led), 32'h0000_BEEF);
    chk("hole_seg", seg_data, 32'h12AB_5678);

    wr(A_CNT, 2'b01, 32'h8000_0000);
    wr(A_CNT, 2'b10, 32'h0000_1234);
    idle(8);
    push_exp(32'h0); rd_chk("cnt_subword_ign", A_CNT);

    wr(A_CNT, 2'b10, 32'h8000_0000);
    idle(12);
    push_exp(32'd3); rd_chk("cnt_run12", A_CNT);
    wr(A_CNT, 2'b10, 32'hFFFF_FFFF);
    idle(20);
    push_exp(32'd3); rd_chk("cnt_hold", A_CNT);
    wr(A_CNT, 2'b10, 32'h8000_0000);
    push_exp(32'd0); rd_chk("cnt_restart", A_CNT);

    wr(A_CNT, 2'b10, 32'h8000_0000);
    force dut.cnt_ms = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_ms;
    push_exp(32'hFFFF_FFFF); rd_chk("cnt_preload", A_CNT);
    idle(4);
    push_exp(32'd0); rd_chk("cnt_wrap", A_CNT);
    idle(3);
    wr(A_CNT, 2'b10, 32'h8000_0000);
    push_exp(32'd0); rd_chk("cnt_start_wins", A_CNT);
    idle(3);
    push_exp(32'd0); rd_chk("cnt_pre_restart3", A_CNT);
    idle(1);
    push_exp(32'd1); rd_chk("cnt_pre_restart4", A_CNT);

    for (int p = 0; p < 10; p++) begin
      key[2] = (p % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        idle(1);
        push_exp(32'h0); rd_chk("key_bounce", A_KEY);
      end
    end
    key[2] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      idle(1);
      push_exp(32'h0); rd_chk("key_settling", A_KEY);
    end
    idle(1);
    push_exp(32'h4); rd_chk("key_accept", A_KEY);

    dram_rdata  = 32'hCAFE_F00D;
    perip_addr  = DRAM_BASE + 32'h101;
    perip_mask  = 2'b00;
    perip_wdata = 32'h0000_5A00;
    perip_wen   = 1'b1;
    push_exp(32'hCAFE_F00D); sb_cmp("dram_rdata");
    chk("dram_addr", 32'(dram_addr), 32'h40);
    chk("dram_wen_hi", 32'(dram_wen), 32'h1);
    chk("dram_byte", 32'(dram_byte), 32'h1);
    chk("dram_mask", 32'(dram_mask), 32'h0);
    chk("dram_wdata", dram_wdata, 32'h0000_5A00);
    perip_wen = 1'b0;
    #1;
    chk("dram_wen_lo", 32'(dram_wen), 32'h0);
    perip_wen  = 1'b1;
    perip_addr = DRAM_BASE + 32'h3FFFC;
    #1;
    chk("dram_top_hit", 32'(dram_wen), 32'h1);
    perip_addr = DRAM_BASE + 32'h40000;
    #1;
    chk("dram_end_miss", 32'(dram_wen), 32'h0);
    perip_wen = 1'b0;
    idle(1);

    perip_addr  = 32'h8030_0000;
    perip_mask  = 2'b10;
    perip_wdata = 32'hFFFF_FFFF;
    perip_wen   = 1'b1;
    #1;
    chk("miss_dram_wen", 32'(dram_wen), 32'h0);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    perip_wen = 1'b0;
    chk("miss_led", 32'(led), 32'h0000_BEEF);
    chk("miss_seg", seg_data, 32'h12AB_5678);
    push_exp(32'h0); rd_chk("miss_rd", 32'h8030_0000);

    wr(A_LED, 2'b10, 32'h0000_00FF);
    wr(A_CNT, 2'b10, 32'h8000_0000);
    idle(6);
    chk("pre_rst_led", 32'(led), 32'h0000_00FF);
    push_exp(32'd1); rd_chk("pre_rst_cnt", A_CNT);
    push_exp(32'h4); rd_chk("pre_rst_key", A_KEY);
    idle(1);
    #1 cpu_rst = 1'b1;
    #1;
    chk("arst_led", 32'(led), 32'h0);
    chk("arst_seg", seg_data, 32'h0);
    rd_chk_after_rst();
    idle(1);
    cpu_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  task automatic rd_chk_after_rst();
    push_exp(32'h0); rd_chk("arst_cnt", A_CNT);
    push_exp(32'h0); rd_chk("arst_key", A_KEY);
  endtask

endmodule
